seq_generator: RTL and testbench

Serial pattern transmitter that drives the bit stream consumed by the team's sequence detectors. On a start pulse it latches a PAT_W-bit pattern and shifts it out MSB first, one bit per clock, a programmable number of times with an optional idle gap between repetitions. A `mark` strobe flags the last bit of each instance, which is the cycle where a matching detector's `z` is expected to respond. It sits in test fixtures and link stimulus paths, feeding the detector's `x` input directly.

---
 rtl/seq_generator.sv | 148 ++++++++++++++
 tb/tb_seq_generator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_generator.sv
// Serial pattern transmitter: shifts a latched pattern out MSB first, a programmable
// number of times with an optional idle gap, flagging the last bit of each instance.
module seq_generator #(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 8,
  parameter int   GAP_W    = 4,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             x,
  output logic             valid,
  output logic             mark,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] remain;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_dec;

  assign idx_dec = idx - 1'b1;

  // idx always names the bit currently on x; remain counts instances still
  // owed including the one in flight, so it never goes below 1 while sending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pat_q   <= '0;
      remain  <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      idx     <= '0;
      x       <= IDLE_BIT;
      valid   <= 1'b0;
      mark    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      mark <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pat_q  <= pattern;
            remain <= repeat_n;
            gap_q  <= gap;
            busy   <= 1'b1;
            if (repeat_n == '0) begin
              state <= DONE;
              done  <= 1'b1;
              x     <= IDLE_BIT;
              valid <= 1'b0;
            end else begin
              state <= SEND;
              idx   <= TOP_IDX;
              x     <= pattern[PAT_W-1];
              valid <= 1'b1;
            end
          end
        end

        SEND: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            x     <= IDLE_BIT;
            valid <= 1'b0;
          end else if (idx == '0) begin
            if (remain == CNT_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
              x     <= IDLE_BIT;
              valid <= 1'b0;
            end else begin
              remain <= remain - 1'b1;
              if (gap_q == '0) begin
                idx   <= TOP_IDX;
                x     <= pat_q[PAT_W-1];
                valid <= 1'b1;
              end else begin
                state   <= GAP;
                gap_cnt <= gap_q;
                x       <= IDLE_BIT;
                valid   <= 1'b0;
              end
            end
          end else begin
            idx   <= idx_dec;
            x     <= pat_q[idx_dec];
            valid <= 1'b1;
            mark  <= (idx_dec == '0);
          end
        end

        GAP: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            x     <= IDLE_BIT;
            valid <= 1'b0;
          end else if (gap_cnt == GAP_W'(1)) begin
            state <= SEND;
            idx   <= TOP_IDX;
            x     <= pat_q[PAT_W-1];
            valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          x     <= IDLE_BIT;
          valid <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          x     <= IDLE_BIT;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_generator.sv
// Self-checking bench for seq_generator: a timing-formula model checked every
// cycle, plus literal expectations for each directed transfer.
module tb_seq_generator;

  localparam int   PAT_W    = 4;
  localparam int   CNT_W    = 8;
  localparam int   GAP_W    = 4;
  localparam logic IDLE_BIT = 1'b1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] repeat_n = '0;
  logic [GAP_W-1:0] gap = '0;
  logic             x, valid, mark, busy, done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: one transfer described by its start cycle and latched parameters.
  bit               act = 1'b0;
  bit               aborted = 1'b0;
  int               t0 = 0;
  int               abort_cyc = 0;
  logic [PAT_W-1:0] m_pat = '0;
  int               m_r = 0;
  int               m_gap = 0;

  seq_generator #(
    .PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W), .IDLE_BIT(IDLE_BIT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pattern), .repeat_n(repeat_n), .gap(gap),
    .x(x), .valid(valid), .mark(mark), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
    end
  endtask

  // Expected outputs in cycle c, derived from the instance/period timing formulas.
  function automatic void model_out(input int c, output logic ex, output logic ev,
                                    output logic em, output logic eb, output logic ed);
    int off, period, total, k;
    ex = IDLE_BIT; ev = 1'b0; em = 1'b0; eb = 1'b0; ed = 1'b0;
    if (!act || c < t0) return;
    if (aborted && c >= abort_cyc) return;
    off = c - t0;
    if (m_r == 0) begin
      if (off == 0) begin ed = 1'b1; eb = 1'b1; end
      return;
    end
    period = PAT_W + m_gap;
    total  = m_r * PAT_W + (m_r - 1) * m_gap;
    if (off < total) begin
      eb = 1'b1;
      k  = off % period;
      if (k < PAT_W) begin
        ev = 1'b1;
        ex = m_pat[PAT_W-1-k];
        em = (k == PAT_W - 1);
      end
    end else if (off == total) begin
      ed = 1'b1;
      eb = 1'b1;
    end
  endfunction

  // Model update at each edge: accept start when idle, cancel on abort while sending.
  always @(posedge clk) begin
    logic ex, ev, em, eb, ed;
    if (rst) begin
      act = 1'b0;
      aborted = 1'b0;
    end else begin
      model_out(cyc, ex, ev, em, eb, ed);
      if (!eb && start) begin
        act = 1'b1;
        aborted = 1'b0;
        t0 = cyc + 1;
        m_pat = pattern;
        m_r = int'(repeat_n);
        m_gap = int'(gap);
      end else if (eb && !ed && abort) begin
        aborted = 1'b1;
        abort_cyc = cyc + 1;
      end
    end
    cyc = cyc + 1;
  end

  always @(posedge rst) begin
    act = 1'b0;
    aborted = 1'b0;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic ex, ev, em, eb, ed;
    model_out(cyc, ex, ev, em, eb, ed);
    checkOutput($sformatf("x@%0d", cyc), 64'(x), 64'(ex));
    checkOutput($sformatf("valid@%0d", cyc), 64'(valid), 64'(ev));
    checkOutput($sformatf("mark@%0d", cyc), 64'(mark), 64'(em));
    checkOutput($sformatf("busy@%0d", cyc), 64'(busy), 64'(eb));
    checkOutput($sformatf("done@%0d", cyc), 64'(done), 64'(ed));
  end

  // Launch one transfer and record what the DUT emits relative to the start cycle.
  task automatic applyStimulus(input logic [PAT_W-1:0] p, input int r, input int g,
                               input int abort_at, input bit spam, input bit abort_with_start,
                               output logic [63:0] stream, output int nbits,
                               output logic [63:0] mmask, output logic [63:0] vmask,
                               output int done_off, output int busy_len);
    int t, off;
    bit finished;
    @(negedge clk);
    pattern = p; repeat_n = 8'(r); gap = 4'(g);
    start = 1'b1; abort = abort_with_start;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    t = cyc;
    stream = '0; nbits = 0; mmask = '0; vmask = '0; done_off = -1; busy_len = 0;
    finished = 1'b0;
    for (int i = 0; i < 200; i++) begin
      off = cyc - t;
      if (busy !== 1'b1) begin
        finished = 1'b1;
        break;
      end
      busy_len++;
      if (valid === 1'b1) begin
        stream = {stream[62:0], x};
        nbits++;
        if (off < 64) vmask[off] = 1'b1;
      end
      if (mark === 1'b1 && off < 64) mmask[off] = 1'b1;
      if (done === 1'b1) done_off = off;
      abort = (abort_at >= 0 && off == abort_at - 1);
      start = spam && (done !== 1'b1) && (off % 3 == 1);
      if (spam) pattern = ~p;
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: busy still high after 200 cycles, expected it to fall");
    end
  endtask

  logic [63:0] s, mm, vm;
  int nb, dof, bl;

  initial begin
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_x", 64'(x), 64'(1));
    checkOutput("rst_valid", 64'(valid), 64'(0));
    checkOutput("rst_mark", 64'(mark), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single instance 0110");
    applyStimulus(4'b0110, 1, 0, -1, 1'b0, 1'b0, s, nb, mm, vm, dof, bl);
    checkOutput("s2_stream", s, 64'b0110);
    checkOutput("s2_nbits", 64'(nb), 64'(4));
    checkOutput("s2_mark", mm, 64'h8);
    checkOutput("s2_valid", vm, 64'hF);
    checkOutput("s2_done", 64'(dof), 64'(4));
    checkOutput("s2_busy", 64'(bl), 64'(5));

    $display("[TB] three instances back to back");
    applyStimulus(4'b0110, 3, 0, -1, 1'b0, 1'b0, s, nb, mm, vm, dof, bl);
    checkOutput("s3_stream", s, 64'b011001100110);
    checkOutput("s3_nbits", 64'(nb), 64'(12));
    checkOutput("s3_mark", mm, 64'h888);
    checkOutput("s3_valid", vm, 64'hFFF);
    checkOutput("s3_done", 64'(dof), 64'(12));

    $display("[TB] two instances with gap 2");
    applyStimulus(4'b0110, 2, 2, -1, 1'b0, 1'b0, s, nb, mm, vm, dof, bl);
    checkOutput("s4_stream", s, 64'b01100110);
    checkOutput("s4_mark", mm, 64'h208);
    checkOutput("s4_valid", vm, 64'h3CF);
    checkOutput("s4_done", 64'(dof), 64'(10));
    checkOutput("s4_busy", 64'(bl), 64'(11));

    $display("[TB] zero repeats");
    applyStimulus(4'b0110, 0, 3, -1, 1'b0, 1'b0, s, nb, mm, vm, dof, bl);
    checkOutput("s5a_nbits", 64'(nb), 64'(0));
    checkOutput("s5a_done", 64'(dof), 64'(0));
    checkOutput("s5a_busy", 64'(bl), 64'(1));

    $display("[TB] start pulses while busy");
    applyStimulus(4'b0110, 2, 0, -1, 1'b1, 1'b0, s, nb, mm, vm, dof, bl);
    checkOutput("s5b_stream", s, 64'b01100110);
    checkOutput("s5b_mark", mm, 64'h88);
    checkOutput("s5b_done", 64'(dof), 64'(8));
    checkOutput("s5b_busy", 64'(bl), 64'(9));

    $display("[TB] abort at t+5");
    applyStimulus(4'b0110, 3, 0, 5, 1'b0, 1'b0, s, nb, mm, vm, dof, bl);
    checkOutput("s6_stream", s, 64'b01100);
    checkOutput("s6_mark", mm, 64'h8);
    checkOutput("s6_done", 64'(dof), 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("s6_busy", 64'(bl), 64'(5));

    $display("[TB] start after abort, with abort held alongside start");
    applyStimulus(4'b1011, 1, 1, -1, 1'b0, 1'b1, s, nb, mm, vm, dof, bl);
    checkOutput("s7_stream", s, 64'b1011);
    checkOutput("s7_mark", mm, 64'h8);
    checkOutput("s7_done", 64'(dof), 64'(4));

    $display("[TB] reset in the middle of a transfer");
    @(negedge clk);
    pattern = 4'b0110; repeat_n = 8'd3; gap = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("pre_rst_valid", 64'(valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_x", 64'(x), 64'(1));
    checkOutput("mid_rst_valid", 64'(valid), 64'(0));
    checkOutput("mid_rst_mark", 64'(mark), 64'(0));
    checkOutput("mid_rst_busy", 64'(busy), 64'(0));
    checkOutput("mid_rst_done", 64'(done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("post_rst_busy", 64'(busy), 64'(0));
    checkOutput("post_rst_valid", 64'(valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
